fp_int_to_fp128: RTL and testbench

- Multi-cycle converter from a 128-bit integer (signed or unsigned) to IEEE 754 binary128.
- Layout: sign[127], exp[126:112] with bias 16383, sig[111:0].
- It is the inverse path of the FP128 truncate/convert-to-integer unit and sits in the same FP128 execution cluster.
- Normalization is iterative (leading-zero shift loop); rounding follows the selected IEEE rounding mode.
- Handshake is ld/busy/done.

---
 rtl/fp_int_to_fp128_if.sv | 16 +
 rtl/fp_int_to_fp128.sv | 143 ++++++++++++++
 tb/tb_fp_int_to_fp128.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_int_to_fp128_if.sv
// Handshake and data bundle for the 128-bit integer to binary128 converter.
// The master drives the request fields; the slave returns the result and status.
interface fp_int_to_fp128_if;
  logic         ce;
  logic         ld;
  logic         op;
  logic [2:0]   rm;
  logic [127:0] i;
  logic [127:0] o;
  logic         done;
  logic         busy;
  logic         inexact;

  modport master (output ce, ld, op, rm, i, input o, done, busy, inexact);
  modport slave  (input ce, ld, op, rm, i, output o, done, busy, inexact);
endinterface

// File: rtl/fp_int_to_fp128.sv
// Multi-cycle 128-bit integer to IEEE 754 binary128 converter.
// Normalizes with coarse/fine left shifts, then rounds in a single cycle.
module fp_int_to_fp128 #(
  parameter int BIAS   = 16383,
  parameter int COARSE = 8
) (
  input logic               clk,
  input logic               rst,
  fp_int_to_fp128_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;

  logic [1:0]   state_r;
  logic         sgn_r;
  logic         zero_r;
  logic [2:0]   rm_r;
  logic [127:0] mag_r;
  logic [14:0]  exp_r;
  logic [127:0] o_r;
  logic         done_r;
  logic         busy_r;
  logic         inexact_r;

  logic         sgn_in_s;
  logic [127:0] mag_in_s;
  logic [111:0] pre_s;
  logic         lsb_s;
  logic         g_s;
  logic         st_s;
  logic         up_s;
  logic [112:0] sum_s;
  logic [111:0] sig_s;
  logic [14:0]  exp_rnd_s;

  // Unknown rounding modes fall back to round-to-nearest-even.
  function automatic logic round_up(input logic [2:0] rm, input logic sgn,
                                    input logic lsb, input logic g, input logic st);
    logic up;
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = sgn & (g | st);
      3'd3:    up = ~sgn & (g | st);
      3'd4:    up = g;
      default: up = g & (st | lsb);
    endcase
    return up;
  endfunction

  assign bus.o       = o_r;
  assign bus.done    = done_r;
  assign bus.busy    = busy_r;
  assign bus.inexact = inexact_r;

  // Operand capture: sign and two's-complement magnitude.
  always_comb begin
    sgn_in_s = bus.op & bus.i[127];
    if (sgn_in_s) begin
      mag_in_s = ~bus.i + 128'd1;
    end else begin
      mag_in_s = bus.i;
    end
  end

  // Rounding of the normalized magnitude; a carry out renormalizes to 1.0.
  always_comb begin
    pre_s = mag_r[126:15];
    lsb_s = mag_r[15];
    g_s   = mag_r[14];
    st_s  = |mag_r[13:0];
    up_s  = round_up(rm_r, sgn_r, lsb_s, g_s, st_s);
    sum_s = {1'b0, pre_s} + {112'd0, up_s};
    if (sum_s[112]) begin
      sig_s     = 112'd0;
      exp_rnd_s = exp_r + 15'd1;
    end else begin
      sig_s     = sum_s[111:0];
      exp_rnd_s = exp_r;
    end
  end

  // Control FSM, normalization datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      sgn_r     <= 1'b0;
      zero_r    <= 1'b0;
      rm_r      <= 3'd0;
      mag_r     <= 128'd0;
      exp_r     <= 15'd0;
      o_r       <= 128'd0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      inexact_r <= 1'b0;
    end else if (bus.ce) begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.ld) begin
            sgn_r   <= sgn_in_s;
            mag_r   <= mag_in_s;
            rm_r    <= bus.rm;
            exp_r   <= 15'(BIAS + 127);
            zero_r  <= (mag_in_s == 128'd0);
            busy_r  <= 1'b1;
            state_r <= NORM;
          end else begin
            state_r <= IDLE;
          end
        end
        NORM: begin
          if (zero_r || mag_r[127]) begin
            state_r <= ROUND;
          end else if (mag_r[127 -: COARSE] == '0) begin
            mag_r <= mag_r << COARSE;
            exp_r <= exp_r - 15'(COARSE);
          end else begin
            mag_r <= mag_r << 1;
            exp_r <= exp_r - 15'd1;
          end
        end
        ROUND: begin
          if (zero_r) begin
            o_r <= 128'd0;
          end else begin
            o_r <= {sgn_r, exp_rnd_s, sig_s};
          end
          inexact_r <= (g_s | st_s) & ~zero_r;
          done_r    <= 1'b1;
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_int_to_fp128.sv
// Self-checking bench for fp_int_to_fp128: directed plan cases plus random
// operands compared against an arithmetic reference model.
module tb_fp_int_to_fp128;

  localparam int BIAS = 16383;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  fp_int_to_fp128_if bus ();

  fp_int_to_fp128 #(.BIAS(BIAS), .COARSE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Reference: exact value, rounding decided from the discarded remainder.
  function automatic void ref_model(input logic op_v, input logic [2:0] rm_v,
                                    input logic [127:0] i_v, output logic [127:0] o_e,
                                    output logic inx_e, output int lat_e);
    logic         sgn;
    logic [127:0] mag;
    logic [127:0] q;
    logic [127:0] rem;
    logic [127:0] half;
    logic [128:0] qr;
    logic [14:0]  e;
    logic [111:0] sig;
    logic         up;
    int           p;
    int           lz;
    int           drop;
    sgn = op_v & i_v[127];
    mag = sgn ? (128'd0 - i_v) : i_v;
    if (mag == 128'd0) begin
      o_e = 128'd0; inx_e = 1'b0; lat_e = 2;
      return;
    end
    p = 0;
    for (int b = 0; b < 128; b++) if (mag[b]) p = b;
    lz    = 127 - p;
    lat_e = 2 + lz / 8 + lz % 8;
    if (p > 112) begin
      drop = p - 112;
      q    = mag >> drop;
      rem  = mag - (q << drop);
      half = 128'd1 << (drop - 1);
    end else begin
      q    = mag << (112 - p);
      rem  = 128'd0;
      half = 128'd1;
    end
    inx_e = (rem != 128'd0);
    case (rm_v)
      3'd1:    up = 1'b0;
      3'd2:    up = sgn && inx_e;
      3'd3:    up = !sgn && inx_e;
      3'd4:    up = inx_e && (rem >= half);
      default: up = inx_e && ((rem > half) || (rem == half && q[0]));
    endcase
    qr = {1'b0, q} + {128'd0, up};
    e  = 15'(BIAS + p);
    if (qr[113]) begin
      e   = e + 15'd1;
      sig = 112'd0;
    end else begin
      sig = qr[111:0];
    end
    o_e = {sgn, e, sig};
  endfunction

  task automatic start(input logic op_v, input logic [2:0] rm_v, input logic [127:0] i_v);
    @(negedge clk);
    bus.ld = 1'b1; bus.op = op_v; bus.rm = rm_v; bus.i = i_v;
    @(posedge clk); #1;
    bus.ld = 1'b0;
  endtask

  task automatic wait_done(input int already, output int edges);
    edges = already;
    while (!bus.done && edges < 60) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic convert(input string tag, input logic op_v, input logic [2:0] rm_v,
                         input logic [127:0] i_v);
    logic [127:0] o_e;
    logic         inx_e;
    int           lat_e;
    int           edges;
    ref_model(op_v, rm_v, i_v, o_e, inx_e, lat_e);
    start(op_v, rm_v, i_v);
    check({tag, "_busy"}, 128'(bus.busy), 128'd1);
    wait_done(0, edges);
    check({tag, "_lat"}, 128'(edges), 128'(lat_e));
    check({tag, "_o"}, bus.o, o_e);
    check({tag, "_inx"}, 128'(bus.inexact), 128'(inx_e));
    check({tag, "_busy_end"}, 128'(bus.busy), 128'd0);
  endtask

  initial begin
    logic [127:0] rv;
    logic         opr;
    int           edges;
    int           seen_done;
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.ce = 1'b1; bus.ld = 1'b0; bus.op = 1'b0; bus.rm = 3'd0; bus.i = 128'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_o", bus.o, 128'd0);
    check("rst_done", 128'(bus.done), 128'd0);
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_inx", 128'(bus.inexact), 128'd0);
    rst = 1'b0;

    convert("min_mag", 1'b1, 3'd0, 128'd1);
    check("min_mag_const", bus.o, 128'h3FFF0000_00000000_00000000_00000000);
    convert("neg_one", 1'b1, 3'd0, {128{1'b1}});
    check("neg_one_const", bus.o, 128'hBFFF0000_00000000_00000000_00000000);
    convert("most_neg", 1'b1, 3'd0, 128'h80000000_00000000_00000000_00000000);
    check("most_neg_const", bus.o, 128'hC07E0000_00000000_00000000_00000000);
    convert("ones_rne", 1'b0, 3'd0, {128{1'b1}});
    check("ones_rne_const", bus.o, 128'h407F0000_00000000_00000000_00000000);
    convert("ones_rtz", 1'b0, 3'd1, {128{1'b1}});
    check("ones_rtz_const", bus.o, 128'h407EFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);
    convert("tie_rne", 1'b0, 3'd0, 128'h80000000_00000000_00000000_00004000);
    check("tie_rne_const", bus.o, 128'h407E0000_00000000_00000000_00000000);
    convert("tie_rmm", 1'b0, 3'd4, 128'h80000000_00000000_00000000_00004000);
    check("tie_rmm_const", bus.o, 128'h407E0000_00000000_00000000_00000001);
    convert("neg_rdn", 1'b1, 3'd2, 128'h80000000_00000000_00000000_00000001);
    check("neg_rdn_const", bus.o, 128'hC07E0000_00000000_00000000_00000000);
    convert("neg_rup", 1'b1, 3'd3, 128'h80000000_00000000_00000000_00000001);
    check("neg_rup_const", bus.o, 128'hC07DFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);
    convert("zero", 1'b1, 3'd3, 128'd0);
    check("zero_const", bus.o, 128'd0);

    // A second ld while busy must be ignored.
    start(1'b0, 3'd0, 128'd1);
    repeat (2) begin @(posedge clk); #1; end
    bus.ld = 1'b1; bus.i = 128'd5;
    @(posedge clk); #1;
    bus.ld = 1'b0;
    wait_done(3, edges);
    check("ld_busy_lat", 128'(edges), 128'd24);
    check("ld_busy_o", bus.o, 128'h3FFF0000_00000000_00000000_00000000);

    // Five disabled cycles mid-normalization extend latency by five.
    start(1'b0, 3'd0, 128'd1);
    repeat (2) begin @(posedge clk); #1; end
    bus.ce = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("ce_hold_busy", 128'(bus.busy), 128'd1);
    bus.ce = 1'b1;
    wait_done(7, edges);
    check("ce_lat", 128'(edges), 128'd29);
    check("ce_o", bus.o, 128'h3FFF0000_00000000_00000000_00000000);

    // Reset during normalization discards the conversion.
    start(1'b0, 3'd0, 128'd12345);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_busy", 128'(bus.busy), 128'd0);
    check("rst_mid_o", bus.o, 128'd0);
    check("rst_mid_done", 128'(bus.done), 128'd0);
    seen_done = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.done) seen_done++;
    end
    check("rst_mid_nodone", 128'(seen_done), 128'd0);

    for (int k = 0; k < 60; k++) begin
      rv  = {$urandom, $urandom, $urandom, $urandom};
      rv  = rv >> $urandom_range(0, 127);
      opr = 1'($urandom_range(0, 1));
      if (opr && $urandom_range(0, 1) == 1) rv = 128'd0 - rv;
      convert("rand", opr, 3'($urandom_range(0, 7)), rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
